// File: rtl/mac_dot_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer_pkg
//   Shared definitions for the dot-product sequencer that feeds the fused
//   multiply-accumulate unit.
//   - Default widths for operands, memory addresses and the vector length.
//   - Sequencer state encoding (3-bit, IDLE=0 .. HOLD=4).
// -----------------------------------------------------------------------------
package mac_dot_sequencer_pkg;

    localparam int unsigned DEF_BITWIDTH = 32;
    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_LEN_W    = 11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME   = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
//   Upstream control stage for the fused MAC. On an accepted start it reads two
//   len-element vectors from 1-cycle-latency memories, streams the element
//   pairs into the MAC as one contiguous burst (mac_en held high), captures the
//   2*BITWIDTH sum and offers it on a valid/ready port. The MAC clears itself on
//   any edge where mac_en is low, so PRIME (mac_en=0) doubles as the clear.
//
// Ports
//   clk, rstn           clock (rising edge), synchronous active-low reset
//   start, len,         command strobe, element count and vector base
//   a_base, b_base      addresses; sampled only when accepted in IDLE
//   busy                high in every state except IDLE
//   a_en/a_addr/a_rdata memory A read port (data valid one cycle after a_en)
//   b_en/b_addr/b_rdata memory B read port (data valid one cycle after b_en)
//   mac_ain, mac_bin    operands to MAC, pass-through of memory read data
//   mac_en              MAC enable (registered)
//   mac_dout            MAC accumulator value
//   result, result_valid, result_ready   captured dot product handshake
// -----------------------------------------------------------------------------
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int unsigned BITWIDTH = DEF_BITWIDTH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned LEN_W    = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [ADDR_W-1:0]       a_base,
    input  logic [ADDR_W-1:0]       b_base,
    output logic                    busy,
    output logic                    a_en,
    output logic [ADDR_W-1:0]       a_addr,
    input  logic [BITWIDTH-1:0]     a_rdata,
    output logic                    b_en,
    output logic [ADDR_W-1:0]       b_addr,
    input  logic [BITWIDTH-1:0]     b_rdata,
    output logic [BITWIDTH-1:0]     mac_ain,
    output logic [BITWIDTH-1:0]     mac_bin,
    output logic                    mac_en,
    input  logic [2*BITWIDTH-1:0]   mac_dout,
    output logic [2*BITWIDTH-1:0]   result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    seq_state_t        state;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  k;

    // One extra bit so k+2 never overflows when len is at its maximum.
    logic [LEN_W:0]    len_ext;
    logic [LEN_W:0]    k_plus1;
    logic [LEN_W:0]    k_plus2;
    logic              last_elem;
    logic              len_nz;

    assign len_ext   = {1'b0, len_r};
    assign k_plus1   = {1'b0, k} + (LEN_W+1)'(1);
    assign k_plus2   = {1'b0, k} + (LEN_W+1)'(2);
    assign last_elem = (k_plus1 == len_ext);
    assign len_nz    = (len_r != '0);

    // Memory data arrives exactly when the matching mac_en cycle is active,
    // so the operands go straight through.
    assign mac_ain = a_rdata;
    assign mac_bin = b_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            len_r        <= '0;
            k            <= '0;
            busy         <= 1'b0;
            a_en         <= 1'b0;
            b_en         <= 1'b0;
            a_addr       <= '0;
            b_addr       <= '0;
            mac_en       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mac_en <= 1'b0;
                    if (start) begin
                        len_r  <= len;
                        k      <= '0;
                        a_addr <= a_base;
                        b_addr <= b_base;
                        a_en   <= (len != '0);
                        b_en   <= (len != '0);
                        busy   <= 1'b1;
                        state  <= PRIME;
                    end
                end

                // Reads of element 0 are in flight; mac_en stays low so the
                // MAC drops any previous sum at the end of this cycle.
                PRIME: begin
                    if (len_nz) begin
                        a_addr <= a_addr + ADDR_W'(1);
                        b_addr <= b_addr + ADDR_W'(1);
                        a_en   <= (len_ext > (LEN_W+1)'(1));
                        b_en   <= (len_ext > (LEN_W+1)'(1));
                        mac_en <= 1'b1;
                        state  <= RUN;
                    end else begin
                        a_en   <= 1'b0;
                        b_en   <= 1'b0;
                        mac_en <= 1'b0;
                        state  <= CAPTURE;
                    end
                end

                // Cycle k: element k is on the read data, the address points
                // one element ahead and reads stop once the last one is issued.
                RUN: begin
                    if (last_elem) begin
                        a_en   <= 1'b0;
                        b_en   <= 1'b0;
                        mac_en <= 1'b0;
                        state  <= CAPTURE;
                    end else begin
                        k      <= k + LEN_W'(1);
                        a_addr <= a_addr + ADDR_W'(1);
                        b_addr <= b_addr + ADDR_W'(1);
                        a_en   <= (k_plus2 < len_ext);
                        b_en   <= (k_plus2 < len_ext);
                        mac_en <= 1'b1;
                    end
                end

                CAPTURE: begin
                    mac_en       <= 1'b0;
                    result       <= mac_dout;
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end

                HOLD: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    a_en         <= 1'b0;
                    b_en         <= 1'b0;
                    mac_en       <= 1'b0;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_sequencer
//   Dot-product unit built from mac_dot_sequencer, a behavioural MAC and two
//   behavioural 1-cycle-latency memories, driven by directed jobs with
//   hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    localparam int unsigned BW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned LW = 11;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [LW-1:0]     len;
    logic [AW-1:0]     a_base;
    logic [AW-1:0]     b_base;
    logic              busy;
    logic              a_en;
    logic [AW-1:0]     a_addr;
    logic [BW-1:0]     a_rdata = '0;
    logic              b_en;
    logic [AW-1:0]     b_addr;
    logic [BW-1:0]     b_rdata = '0;
    logic [BW-1:0]     mac_ain;
    logic [BW-1:0]     mac_bin;
    logic              mac_en;
    logic [2*BW-1:0]   mac_dout = '0;
    logic [2*BW-1:0]   result;
    logic              result_valid;
    logic              result_ready;

    always #5 clk = ~clk;

    mac_dot_sequencer #(
        .BITWIDTH (BW),
        .ADDR_W   (AW),
        .LEN_W    (LW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .len          (len),
        .a_base       (a_base),
        .b_base       (b_base),
        .busy         (busy),
        .a_en         (a_en),
        .a_addr       (a_addr),
        .a_rdata      (a_rdata),
        .b_en         (b_en),
        .b_addr       (b_addr),
        .b_rdata      (b_rdata),
        .mac_ain      (mac_ain),
        .mac_bin      (mac_bin),
        .mac_en       (mac_en),
        .mac_dout     (mac_dout),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // Memories and MAC
    logic [BW-1:0] mem_a [0:1023];
    logic [BW-1:0] mem_b [0:1023];

    always @(posedge clk) begin
        if (a_en) a_rdata <= mem_a[a_addr];
        if (b_en) b_rdata <= mem_b[b_addr];
    end

    always @(posedge clk) begin
        if (mac_en) mac_dout <= mac_dout + ({32'b0, mac_ain} * {32'b0, mac_bin});
        else        mac_dout <= '0;
    end

    // Cycle counter and negedge activity monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         macen_cycles = 0;
    int         macen_rises  = 0;
    int         aen_pulses   = 0;
    int         ben_pulses   = 0;
    logic       prev_macen   = 1'b0;
    logic [AW-1:0] addr_log [0:255];

    always @(negedge clk) begin
        prev_macen <= mac_en;
        if (mac_en) macen_cycles <= macen_cycles + 1;
        if (mac_en && !prev_macen) macen_rises <= macen_rises + 1;
        if (a_en) begin
            addr_log[aen_pulses % 256] <= a_addr;
            aen_pulses <= aen_pulses + 1;
        end
        if (b_en) ben_pulses <= ben_pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [LW-1:0] n, input logic [AW-1:0] ab,
                             input logic [AW-1:0] bb, output int t0);
        start  = 1'b1;
        len    = n;
        a_base = ab;
        b_base = bb;
        tick();
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int tv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tv = cyc;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        int t0;
        int tv;
        bit ok;
        int m0;
        int r0;
        int a0;
        int b0;

        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        rstn         = 1'b0;
        start        = 1'b0;
        len          = '0;
        a_base       = '0;
        b_base       = '0;
        result_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_mac_en", 64'(mac_en), 64'(0));
        check("rst_a_en",   64'(a_en), 64'(0));
        check("rst_valid",  64'(result_valid), 64'(0));
        check("rst_result", result, 64'(0));
        check("rst_a_addr", 64'(a_addr), 64'(0));
        rstn = 1'b1;
        tick();

        // Job 1: [1,2,3,4].[5,6,7,8] = 70
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
        m0 = macen_cycles;
        r0 = macen_rises;
        start_job(11'd4, 10'd0, 10'd0, t0);
        check("j1_busy", 64'(busy), 64'(1));
        wait_valid(tv, ok);
        check("j1_valid_seen", 64'(ok), 64'(1));
        check("j1_latency", 64'(tv - t0), 64'(6));
        check("j1_result", result, 64'd70);
        check("j1_macen_cycles", 64'(macen_cycles - m0), 64'(4));
        check("j1_macen_bursts", 64'(macen_rises - r0), 64'(1));
        handshake();
        check("j1_valid_drop", 64'(result_valid), 64'(0));
        check("j1_busy_drop", 64'(busy), 64'(0));
        check("j1_result_kept", result, 64'd70);

        // Job 2: len=0
        a0 = aen_pulses;
        b0 = ben_pulses;
        start_job(11'd0, 10'd5, 10'd5, t0);
        wait_valid(tv, ok);
        check("j2_valid_seen", 64'(ok), 64'(1));
        check("j2_latency", 64'(tv - t0), 64'(2));
        check("j2_result", result, 64'd0);
        check("j2_no_a_reads", 64'(aen_pulses - a0), 64'(0));
        check("j2_no_b_reads", 64'(ben_pulses - b0), 64'(0));
        handshake();

        // Jobs 3a/3b back to back: 18, then 10 with no carry-over
        mem_a[0] = 3; mem_a[1] = 3;
        mem_b[0] = 3; mem_b[1] = 3;
        mem_a[100] = 2; mem_b[100] = 5;
        start_job(11'd2, 10'd0, 10'd0, t0);
        wait_valid(tv, ok);
        check("j3a_latency", 64'(tv - t0), 64'(4));
        check("j3a_result", result, 64'd18);
        handshake();
        start_job(11'd1, 10'd100, 10'd100, t0);
        wait_valid(tv, ok);
        check("j3b_latency", 64'(tv - t0), 64'(3));
        check("j3b_result", result, 64'd10);
        handshake();

        // Job 4: wrap of the 64-bit sum
        mem_a[200] = 32'hFFFF_FFFF; mem_a[201] = 32'hFFFF_FFFF;
        mem_b[200] = 32'hFFFF_FFFF; mem_b[201] = 32'hFFFF_FFFF;
        start_job(11'd2, 10'd200, 10'd200, t0);
        wait_valid(tv, ok);
        check("j4_result", result, 64'hFFFF_FFFC_0000_0002);
        handshake();

        // Job 5: address wrap 1022,1023,0; start ignored in RUN and HOLD
        mem_a[1022] = 1; mem_a[1023] = 2; mem_a[0] = 3;
        mem_b[10] = 4; mem_b[11] = 5; mem_b[12] = 6;
        a0 = aen_pulses;
        start_job(11'd3, 10'd1022, 10'd10, t0);
        tick();
        start = 1'b1;
        len   = 11'd5;
        tick();
        start = 1'b0;
        wait_valid(tv, ok);
        check("j5_latency", 64'(tv - t0), 64'(5));
        check("j5_result", result, 64'd32);
        check("j5_a_reads", 64'(aen_pulses - a0), 64'(3));
        check("j5_addr0", 64'(addr_log[a0 % 256]), 64'(1022));
        check("j5_addr1", 64'(addr_log[(a0 + 1) % 256]), 64'(1023));
        check("j5_addr2", 64'(addr_log[(a0 + 2) % 256]), 64'(0));
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        check("j5_hold_valid", 64'(result_valid), 64'(1));
        check("j5_hold_busy", 64'(busy), 64'(1));
        check("j5_hold_result", result, 64'd32);
        handshake();
        tick();
        check("j5_idle_busy", 64'(busy), 64'(0));

        // Job 6: reset during RUN of a len=8 job, then a len=1 job
        for (int i = 0; i < 8; i++) begin
            mem_a[300 + i] = 32'(i + 1);
            mem_b[300 + i] = 1;
        end
        mem_a[400] = 4; mem_b[400] = 4;
        start_job(11'd8, 10'd300, 10'd300, t0);
        tick(); tick(); tick();
        check("j6_running", 64'(mac_en), 64'(1));
        rstn = 1'b0;
        tick();
        check("j6_rst_busy",   64'(busy), 64'(0));
        check("j6_rst_mac_en", 64'(mac_en), 64'(0));
        check("j6_rst_a_en",   64'(a_en), 64'(0));
        check("j6_rst_b_en",   64'(b_en), 64'(0));
        check("j6_rst_valid",  64'(result_valid), 64'(0));
        check("j6_rst_a_addr", 64'(a_addr), 64'(0));
        check("j6_rst_b_addr", 64'(b_addr), 64'(0));
        check("j6_rst_result", result, 64'd0);
        rstn = 1'b1;
        tick();
        check("j6_mac_cleared", mac_dout, 64'd0);
        start_job(11'd1, 10'd400, 10'd400, t0);
        wait_valid(tv, ok);
        check("j6_latency", 64'(tv - t0), 64'(3));
        check("j6_result", result, 64'd16);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
